rsa_mmm: RTL and testbench
==========================

Name: rsa_mmm

Overview:
- Bit-serial radix-2 Montgomery modular multiplier; computes R = A·B·2^-WIDTH mod M.
- Sits directly downstream of the RSA exponentiation controller and is driven by its clear_mmm, ld_a and ld_r strobes.
- The controller's step counter sequences the multiplier; this block has no internal start/stop FSM beyond its own step counter.
- Operand muxing (sel1/sel2) and lock registers stay outside this block.

Parameters:
WIDTH, 8, operand/modulus width in bits (≥ 2).

Ports:
clk  input  1  system clock, rising edge.
rstb  input  1  asynchronous active-low reset.
ena  input  1  global clock enable; when 0, all state holds.
clear  input  1  synchronous active-low clear (driven by clear_mmm).
ld_a  input  1  load strobe: capture A, zero the accumulator, restart the step count.
ld_r  input  1  result strobe: register the reduced result onto R.
A  input  WIDTH  multiplier operand, scanned LSB-first; sampled only on ld_a.
B  input  WIDTH  multiplicand; must stay stable for the whole operation.
M  input  WIDTH  modulus; odd, with A, B < M; must stay stable for the whole operation.
R  output  WIDTH  registered Montgomery product.
done  output  1  high once WIDTH iterations have completed since the last ld_a.

Behaviour:
- Reset (rstb=0, asynchronous):
  - a_sr=0, acc=0, step_cnt=0, R=0, done=0.
- Internal state:
  - a_sr: WIDTH bits.
  - acc: WIDTH+2 bits; invariant acc < 2M.
  - step_cnt: $clog2(WIDTH+1) bits.
- Enable:
  - Every action below requires ena=1.
  - With ena=0, nothing changes, including clear handling.
- Priority per enabled cycle: clear=0 > ld_a > step. ld_r is evaluated independently.
- clear=0:
  - a_sr, acc, step_cnt, R and done all go to 0.
  - ld_a and ld_r are ignored that cycle.
- ld_a=1 (clear=1):
  - a_sr<=A, acc<=0, step_cnt<=0, done<=0.
  - No iteration happens on this cycle.
- Step (clear=1, ld_a=0, step_cnt<WIDTH). One iteration per cycle:
  - a0 = a_sr[0].
  - q = acc[0] ^ (a0 & B[0]).
  - acc <= (acc + (a0 ? B : 0) + (q ? M : 0)) >> 1. Compute the sum at WIDTH+3 bits so nothing is lost before the shift.
  - a_sr <= a_sr >> 1; step_cnt <= step_cnt+1.
  - done <= (step_cnt+1 == WIDTH).
- Saturation:
  - At step_cnt==WIDTH, steps stop; acc, a_sr and step_cnt hold until ld_a or clear.
  - done stays at 1 while saturated.
- Step does not depend on ld_r; ld_r=1 with ld_a=0 still steps if step_cnt<WIDTH.
- Final reduction (combinational):
  - red = (acc >= M) ? acc - M : acc, truncated to WIDTH bits.
  - Exactly one conditional subtraction is valid because acc < 2M.
- ld_r=1 (clear=1):
  - R <= red, computed from the acc value present at the start of the cycle (pre-update).
  - This applies even if ld_a is also high that cycle; the capture is then of the old operation.
  - ld_r before done=1 captures a partial value. This is legal but meaningless; it is not flagged.
- Latency:
  - ld_a at cycle t; steps at t+1 … t+WIDTH; done=1 visible from t+WIDTH+1.
  - ld_r at t+WIDTH+1 yields R valid from t+WIDTH+2.
  - This matches the controller sequence: PRE (ld_a), WIDTH step cycles, POST (ld_r).
- Repeated ld_r while saturated (controller EOC state) re-captures the same value; R stays stable.
- Reset or clear mid-operation aborts it fully; the next ld_a starts clean.
- Out-of-contract operands (A ≥ M, B ≥ M, or even M) produce an unspecified R, but must not cause X-propagation or hangs.

Test Plan:
- WIDTH=8, M=13, A=5, B=7: ld_a, 8 step cycles, then ld_r → done=1 at cycle 9 after ld_a; R=1 one cycle after ld_r.
- Mapping case, M=13, A=5, B=3 (R² mod 13) → R=6. Then A=B=1 → R=3 (2^-8 mod 13).
- Width stress, M=255, A=B=254 → R=1. Also M=13, A=B=12 → R=3. Check acc never exceeds 2M−1.
- Toggle ena=0 for 3 cycles in the middle of the steps → step_cnt and acc freeze; result still R=1 (M=13, A=5, B=7); done delayed by exactly 3 cycles.
- Pulse clear=0 at step 4 → R=0, done=0 the next cycle. A fresh ld_a with A=5, B=7, M=13 → R=1.
- Hold ld_r for 5 cycles after done → R constant. Assert rstb=0 asynchronously mid-step → R=0, done=0 immediately.

Source files
------------

// File: rtl/rsa_mmm.sv
// Bit-serial radix-2 Montgomery multiplier: R = A*B*2^-WIDTH mod M.
// Sequenced by an external controller through clear / ld_a / ld_r strobes.
module rsa_mmm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             ld_a,
  input  logic             ld_r,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] R,
  output logic             done
);

  localparam int CW   = $clog2(WIDTH + 1);
  localparam int ACCW = WIDTH + 2;
  localparam int SUMW = WIDTH + 3;
  localparam logic [CW-1:0] LAST    = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [ACCW-1:0]  acc_reg, acc_next;
  logic [CW-1:0]    step_cnt_reg, step_cnt_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic             done_reg, done_next;

  logic             a0;
  logic             q;
  logic             stepping;
  logic [SUMW-1:0]  sum;
  logic [ACCW-1:0]  acc_step;
  logic [ACCW-1:0]  m_ext;
  logic [WIDTH-1:0] red;

  // One Montgomery iteration; q is chosen so the sum is always even.
  always_comb begin
    a0       = a_sr_reg[0];
    q        = acc_reg[0] ^ (a0 & B[0]);
    sum      = {1'b0, acc_reg}
             + (a0 ? {3'b000, B} : {SUMW{1'b0}})
             + (q  ? {3'b000, M} : {SUMW{1'b0}});
    acc_step = ACCW'(sum >> 1);
    m_ext    = {2'b00, M};
    // acc < 2M, so a single conditional subtraction fully reduces it.
    red      = (acc_reg >= m_ext) ? (acc_reg[WIDTH-1:0] - M) : acc_reg[WIDTH-1:0];
    stepping = (step_cnt_reg < LAST);
  end

  always_comb begin
    a_sr_next     = a_sr_reg;
    acc_next      = acc_reg;
    step_cnt_next = step_cnt_reg;
    r_next        = r_reg;
    done_next     = done_reg;
    if (!clear) begin
      a_sr_next     = '0;
      acc_next      = '0;
      step_cnt_next = '0;
      r_next        = '0;
      done_next     = 1'b0;
    end else begin
      // Result capture uses the pre-update accumulator, even alongside ld_a.
      if (ld_r) begin
        r_next = red;
      end
      if (ld_a) begin
        a_sr_next     = A;
        acc_next      = '0;
        step_cnt_next = '0;
        done_next     = 1'b0;
      end else if (stepping) begin
        a_sr_next     = a_sr_reg >> 1;
        acc_next      = acc_step;
        step_cnt_next = step_cnt_reg + CW'(1);
        done_next     = (step_cnt_reg == LAST_M1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_sr_reg     <= '0;
      acc_reg      <= '0;
      step_cnt_reg <= '0;
      r_reg        <= '0;
      done_reg     <= 1'b0;
    end else if (ena) begin
      a_sr_reg     <= a_sr_next;
      acc_reg      <= acc_next;
      step_cnt_reg <= step_cnt_next;
      r_reg        <= r_next;
      done_reg     <= done_next;
    end
  end

  assign R    = r_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_rsa_mmm.sv
// Scoreboard bench for rsa_mmm: expected products come from a modular-inverse
// reference model and are queued when ld_r is driven, popped when R updates.
module tb_rsa_mmm;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         ena = 1'b1;
  logic         clear = 1'b1;
  logic         ld_a = 1'b0;
  logic         ld_r = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] M = '0;
  logic [W-1:0] R;
  logic         done;

  int           n_cmp = 0;
  int           n_err = 0;
  int           max_acc = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  rsa_mmm #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .clear(clear),
    .ld_a (ld_a),
    .ld_r (ld_r),
    .A    (A),
    .B    (B),
    .M    (M),
    .R    (R),
    .done (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, expv);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // A*B*2^-W mod m, via brute-force inverse of 2^W.
  function automatic logic [W-1:0] mont_ref(input int a, input int b, input int m);
    longint inv = 0;
    for (int x = 0; x < m; x++)
      if (((longint'(x) << W) % m) == 1) inv = x;
    return W'(((longint'(a) * b % m) * inv) % m);
  endfunction

  // All tasks start and end at a falling edge.
  task automatic start_op(input int a, input int b, input int m);
    A    = W'(a);
    B    = W'(b);
    M    = W'(m);
    ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
  endtask

  task automatic wait_done(input int stall_at, input int stall_len, output int cyc);
    cyc     = 0;
    max_acc = 0;
    while (!done && cyc < 200) begin
      if (stall_len > 0 && cyc == stall_at) ena = 1'b0;
      if (stall_len > 0 && cyc == stall_at + stall_len) begin
        chk("freeze_cnt", 32'(dut.step_cnt_reg), 32'(stall_at));
        ena = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (int'(dut.acc_reg) > max_acc) max_acc = int'(dut.acc_reg);
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic capture(input logic [W-1:0] expv, input string tag);
    ld_r = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    ld_r = 1'b0;
    chk(tag, 32'(R), 32'(exp_q.pop_front()));
  endtask

  task automatic run(input int a, input int b, input int m,
                     input int stall_at, input int stall_len, input int exp_cyc,
                     input string tag);
    int cyc;
    start_op(a, b, m);
    wait_done(stall_at, stall_len, cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    capture(mont_ref(a, b, m), {tag, "_R"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstb = 1'b1;
    @(negedge clk);

    run(5, 7, 13, -1, 0, W, "basic");
    chk("done_held", 32'(done), 32'd1);
    run(5, 3, 13, -1, 0, W, "map");
    run(1, 1, 13, -1, 0, W, "inv");
    run(254, 254, 255, -1, 0, W, "wide");
    chk("acc_bound_255", 32'(max_acc < 2 * 255), 32'd1);
    run(12, 12, 13, -1, 0, W, "max13");
    chk("acc_bound_13", 32'(max_acc < 2 * 13), 32'd1);

    // Three frozen cycles mid-operation delay done by exactly three.
    run(5, 7, 13, 3, 3, W + 3, "stall");

    // ld_r together with ld_a captures the finished operation, not the new one.
    start_op(12, 12, 13);
    wait_done(-1, 0, cyc);
    A    = W'(5);
    B    = W'(7);
    ld_a = 1'b1;
    ld_r = 1'b1;
    exp_q.push_back(mont_ref(12, 12, 13));
    @(negedge clk);
    ld_a = 1'b0;
    ld_r = 1'b0;
    chk("ldar_R", 32'(R), 32'(exp_q.pop_front()));
    chk("ldar_done", 32'(done), 32'd0);
    wait_done(-1, 0, cyc);
    chk("ldar_lat", 32'(cyc), 32'(W));
    capture(mont_ref(5, 7, 13), "ldar_new_R");

    // Synchronous clear at step 4 aborts the operation.
    start_op(5, 3, 13);
    repeat (4) @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    chk("clr_R", 32'(R), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    run(5, 7, 13, -1, 0, W, "postclr");

    // Held ld_r while saturated keeps R stable.
    ld_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mont_ref(5, 7, 13));
      @(negedge clk);
      chk("hold_R", 32'(R), 32'(exp_q.pop_front()));
    end
    ld_r = 1'b0;

    // Asynchronous reset between edges clears outputs immediately.
    start_op(5, 3, 13);
    repeat (3) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("arst_R", 32'(R), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    run(5, 3, 13, -1, 0, W, "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
